// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the pipeline WB
//               stage and one long-latency unit. The pipeline always wins;
//               unit results wait in a small FIFO and drain into idle WB
//               slots. A starvation counter asks the pipeline for a bubble
//               so queued results always retire. Queued entries overwritten
//               by a younger pipeline write to the same register are killed
//               and retire silently, which keeps WAW order intact.
// Revision    : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_wb,
    input  logic [4:0]  WriteReg_wb,
    input  logic [31:0] RegWriteData_wb,
    input  logic        McValid,
    input  logic [4:0]  McReg,
    input  logic [31:0] McData,
    output logic        McReady,
    output logic        StallReq_wb,
    output logic        RF_We,
    output logic [4:0]  RF_Addr,
    output logic [31:0] RF_Data
);

    localparam int c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W    = $clog2(DEPTH + 1);
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0]    c_FULL_CNT  = c_CNT_W'(DEPTH);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

    // Pending-result storage: one slot per entry plus valid / kill flags.
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_kill;
    logic [4:0]            r_regQ  [DEPTH];
    logic [31:0]           r_dataQ [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    // Starvation tracking and registered outputs.
    logic [c_STARVE_W-1:0] r_starve;
    logic                  r_stall;
    logic                  r_rfWe;
    logic [4:0]            r_rfAddr;
    logic [31:0]           r_rfData;

    // Per-cycle decisions.
    logic                  w_busy;
    logic                  w_full;
    logic                  w_push;
    logic                  w_headExists;
    logic                  w_headKilled;
    logic                  w_headLive;
    logic                  w_pop;
    logic                  w_popWrite;
    logic                  w_headKillNext;
    logic [DEPTH-1:0]      w_killMask;
    logic [c_STARVE_W-1:0] w_starveInc;

    // A write to $0 is architecturally a no-op, so it never occupies the slot.
    assign w_busy       = RegWrite_wb && (WriteReg_wb != 5'd0);
    assign w_full       = (r_count == c_FULL_CNT);
    assign w_push       = McValid && !w_full;
    assign w_headExists = (r_count != '0);
    assign w_headKilled = r_kill[r_head];
    assign w_headLive   = w_headExists && !w_headKilled;

    // Killed heads carry no data, so they may leave even while the slot is busy.
    assign w_pop        = w_headExists && (!w_busy || w_headKilled);
    assign w_popWrite   = w_pop && w_headLive && (r_regQ[r_head] != 5'd0);

    // Every queued entry targeting the pipeline's register is older and now dead.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_killMask
        assign w_killMask[gi] = w_busy && r_valid[gi] && (r_regQ[gi] == WriteReg_wb);
    end

    assign w_headKillNext = w_headKilled | w_killMask[r_head];

    // Saturating increment so the counter parks at the limit.
    assign w_starveInc = (r_starve == c_STARVE_LIM) ? r_starve : (r_starve + c_STARVE_ONE);

    // FIFO bookkeeping: kill marking, pop of the head, push at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_kill  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regQ[i]  <= '0;
                r_dataQ[i] <= '0;
            end
        end else begin
            r_kill <= r_kill | w_killMask;

            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_kill[r_head]  <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end

            // The pushed entry is younger than this cycle's pipeline write.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_kill[r_tail]  <= 1'b0;
                r_regQ[r_tail]  <= McReg;
                r_dataQ[r_tail] <= McData;
                r_tail          <= r_tail + c_PTR_ONE;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Count cycles a live head waits; request a bubble once the limit is hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else if (w_pop) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else if (!w_headExists || w_headKillNext) begin
            r_starve <= '0;
        end else begin
            r_starve <= w_starveInc;
            if (w_starveInc == c_STARVE_LIM) begin
                r_stall <= 1'b1;
            end
        end
    end

    // Register-file port: pipeline first, then a live queued result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rfWe   <= 1'b0;
            r_rfAddr <= '0;
            r_rfData <= '0;
        end else if (w_busy) begin
            r_rfWe   <= 1'b1;
            r_rfAddr <= WriteReg_wb;
            r_rfData <= RegWriteData_wb;
        end else if (w_popWrite) begin
            r_rfWe   <= 1'b1;
            r_rfAddr <= r_regQ[r_head];
            r_rfData <= r_dataQ[r_head];
        end else begin
            r_rfWe   <= 1'b0;
        end
    end

    assign McReady     = !w_full;
    assign StallReq_wb = r_stall;
    assign RF_We       = r_rfWe;
    assign RF_Addr     = r_rfAddr;
    assign RF_Data     = r_rfData;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int N_RANDOM     = 3000;

    logic        clk;
    logic        rst;
    logic        RegWrite_wb;
    logic [4:0]  WriteReg_wb;
    logic [31:0] RegWriteData_wb;
    logic        McValid;
    logic [4:0]  McReg;
    logic [31:0] McData;
    logic        McReady;
    logic        StallReq_wb;
    logic        RF_We;
    logic [4:0]  RF_Addr;
    logic [31:0] RF_Data;

    int nCompared   = 0;
    int nMismatched = 0;

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .RegWrite_wb     (RegWrite_wb),
        .WriteReg_wb     (WriteReg_wb),
        .RegWriteData_wb (RegWriteData_wb),
        .McValid         (McValid),
        .McReg           (McReg),
        .McData          (McData),
        .McReady         (McReady),
        .StallReq_wb     (StallReq_wb),
        .RF_We           (RF_We),
        .RF_Addr         (RF_Addr),
        .RF_Data         (RF_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic        eReady;
        logic        eStall;
        logic        eWe;
        logic        chkAD;
        logic [4:0]  eAddr;
        logic [31:0] eData;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          k;
    } ent_t;

    vec_t vecs[11];

    function automatic vec_t mkVec(logic r, logic we, logic [4:0] wreg, logic [31:0] wdata,
                                   logic mv, logic [4:0] mreg, logic [31:0] mdata,
                                   logic eReady, logic eStall, logic eWe, logic chkAD,
                                   logic [4:0] eAddr, logic [31:0] eData);
        vec_t v;
        v.rst = r;       v.we = we;       v.wreg = wreg;   v.wdata = wdata;
        v.mv = mv;       v.mreg = mreg;   v.mdata = mdata;
        v.eReady = eReady; v.eStall = eStall; v.eWe = eWe; v.chkAD = chkAD;
        v.eAddr = eAddr; v.eData = eData;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic step(input logic r, input logic we, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic mv, input logic [4:0] mreg,
                        input logic [31:0] mdata);
        rst             = r;
        RegWrite_wb     = we;
        WriteReg_wb     = wreg;
        RegWriteData_wb = wdata;
        McValid         = mv;
        McReg           = mreg;
        McData          = mdata;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic eReady, input logic eStall,
                             input logic eWe, input logic chkAD, input logic [4:0] eAddr,
                             input logic [31:0] eData);
        chk({tag, ".McReady"},     {31'd0, McReady},     {31'd0, eReady});
        chk({tag, ".StallReq_wb"}, {31'd0, StallReq_wb}, {31'd0, eStall});
        chk({tag, ".RF_We"},       {31'd0, RF_We},       {31'd0, eWe});
        if (chkAD) begin
            chk({tag, ".RF_Addr"}, {27'd0, RF_Addr}, {27'd0, eAddr});
            chk({tag, ".RF_Data"}, RF_Data, eData);
        end
    endtask

    // Reference model state
    ent_t        q[$];
    int          waitCnt;
    bit          stallE;
    bit          weE;
    logic [4:0]  addrE;
    logic [31:0] dataE;

    initial begin
        rst = 1'b0; RegWrite_wb = 1'b0; WriteReg_wb = '0; RegWriteData_wb = '0;
        McValid = 1'b0; McReg = '0; McData = '0;

        // ---------------- directed vector table ----------------
        //                   rst we wreg wdata         mv mreg mdata          rdy stl we chk addr data
        vecs[0]  = mkVec(1, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 1, 5'd0,  32'h0);
        vecs[1]  = mkVec(0, 1, 5'd5, 32'h1234,     0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd5,  32'h1234);
        vecs[2]  = mkVec(0, 0, 5'd0, 32'h0,        1, 5'd7,  32'hCAFE,     1, 0, 0, 1, 5'd5,  32'h1234);
        vecs[3]  = mkVec(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd7,  32'hCAFE);
        vecs[4]  = mkVec(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 1, 5'd7,  32'hCAFE);
        vecs[5]  = mkVec(0, 1, 5'd1, 32'h11,       1, 5'd10, 32'hA0,       1, 0, 1, 1, 5'd1,  32'h11);
        vecs[6]  = mkVec(0, 1, 5'd2, 32'h22,       1, 5'd11, 32'hA1,       0, 0, 1, 1, 5'd2,  32'h22);
        vecs[7]  = mkVec(0, 1, 5'd3, 32'h33,       1, 5'd12, 32'hA2,       0, 0, 1, 1, 5'd3,  32'h33);
        vecs[8]  = mkVec(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd10, 32'hA0);
        vecs[9]  = mkVec(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd11, 32'hA1);
        vecs[10] = mkVec(0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 5'd0,  32'h0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].wreg, vecs[i].wdata,
                 vecs[i].mv, vecs[i].mreg, vecs[i].mdata);
            expectOut($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eStall,
                      vecs[i].eWe, vecs[i].chkAD, vecs[i].eAddr, vecs[i].eData);
        end

        // ---------------- starvation ----------------
        step(0, 1, 5'd1, 32'h1, 1, 5'd13, 32'hD00D);
        expectOut("starve.push", 1, 0, 1, 1, 5'd1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'd1, 32'h2 + i, 0, 5'd0, 32'h0);
            expectOut($sformatf("starve.wait%0d", i + 1), 1, 0, 1, 1, 5'd1, 32'h2 + i);
        end
        step(0, 1, 5'd1, 32'h9, 0, 5'd0, 32'h0);
        expectOut("starve.limit", 1, 1, 1, 1, 5'd1, 32'h9);
        step(0, 1, 5'd2, 32'hA, 0, 5'd0, 32'h0);
        expectOut("starve.ignored", 1, 1, 1, 1, 5'd2, 32'hA);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expectOut("starve.bubble", 1, 0, 1, 1, 5'd13, 32'hD00D);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expectOut("starve.after", 1, 0, 0, 0, 5'd0, 32'h0);

        // ---------------- kill (WAW) ----------------
        step(0, 1, 5'd1, 32'h1, 1, 5'd9, 32'hAAAA);
        expectOut("kill.push", 1, 0, 1, 1, 5'd1, 32'h1);
        step(0, 1, 5'd9, 32'hBBBB, 1, 5'd9, 32'hCCCC);
        expectOut("kill.pipe", 0, 0, 1, 1, 5'd9, 32'hBBBB);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expectOut("kill.silent", 1, 0, 0, 0, 5'd0, 32'h0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expectOut("kill.younger", 1, 0, 1, 1, 5'd9, 32'hCCCC);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expectOut("kill.empty", 1, 0, 0, 0, 5'd0, 32'h0);

        // ---------------- writes to $0 ----------------
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h55);
        expectOut("zero.push", 1, 0, 0, 0, 5'd0, 32'h0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expectOut("zero.pop", 1, 0, 0, 0, 5'd0, 32'h0);
        step(0, 1, 5'd0, 32'h77, 0, 5'd0, 32'h0);
        expectOut("zero.pipe", 1, 0, 0, 0, 5'd0, 32'h0);

        // ---------------- reset mid-operation ----------------
        step(0, 1, 5'd1, 32'h1, 1, 5'd14, 32'hE0);
        expectOut("rst.push1", 1, 0, 1, 1, 5'd1, 32'h1);
        step(0, 1, 5'd2, 32'h2, 1, 5'd15, 32'hF0);
        expectOut("rst.push2", 0, 0, 1, 1, 5'd2, 32'h2);
        step(1, 1, 5'd3, 32'h3, 1, 5'd16, 32'h160);
        expectOut("rst.applied", 1, 0, 0, 1, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            expectOut($sformatf("rst.nostale%0d", i), 1, 0, 0, 0, 5'd0, 32'h0);
        end

        // ---------------- randomized run vs reference model ----------------
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        q.delete(); waitCnt = 0; stallE = 0; weE = 0; addrE = '0; dataE = '0;

        for (int c = 0; c < N_RANDOM; c++) begin
            logic        r, we, mv, busy, pop, pushOk;
            logic [4:0]  wreg, mreg;
            logic [31:0] wdata, mdata;
            ent_t        e;

            r     = ($urandom_range(0, 149) == 0);
            if (stallE && ($urandom_range(0, 1) == 1)) we = 1'b0;
            else we = ($urandom_range(0, 9) < 6);
            wreg  = 5'($urandom_range(0, 3));
            wdata = $urandom;
            mv    = ($urandom_range(0, 1) == 1);
            mreg  = 5'($urandom_range(0, 3));
            mdata = $urandom;

            step(r, we, wreg, wdata, mv, mreg, mdata);

            if (r) begin
                q.delete(); waitCnt = 0; stallE = 0; weE = 0;
            end else begin
                busy   = we && (wreg != 5'd0);
                pop    = (q.size() > 0) && (!busy || q[0].k);
                pushOk = mv && (q.size() < DEPTH);
                if (busy) begin
                    weE = 1; addrE = wreg; dataE = wdata;
                end else if (pop && !q[0].k && (q[0].r != 5'd0)) begin
                    weE = 1; addrE = q[0].r; dataE = q[0].d;
                end else begin
                    weE = 0;
                end
                if (busy) begin
                    foreach (q[i]) if (q[i].r == wreg) q[i].k = 1;
                end
                if (pop) begin
                    q.delete(0); waitCnt = 0; stallE = 0;
                end else if ((q.size() == 0) || q[0].k) begin
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                    if (waitCnt >= STARVE_LIMIT) stallE = 1;
                end
                if (pushOk) begin
                    e.r = mreg; e.d = mdata; e.k = 0;
                    q.push_back(e);
                end
            end

            expectOut($sformatf("rand%0d", c), (q.size() < DEPTH), stallE, weE, weE, addrE, dataE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
